bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels (2..8).
REQ-002 Parameter AW, default 16, address width.
REQ-003 Parameter DW, default 8, data width.
REQ-004 Parameter TO_CYC, default 255, maximum BUSY cycles before timeout abort (1..65535).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 In_Cmd  in  NCH  per-channel one-cycle request strobe.
REQ-008 In_Addr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW].
REQ-009 In_WData  in  NCH*DW  per-channel write data, channel i at bits [i*DW +: DW].
REQ-010 In_RW  in  NCH  per-channel direction, 1 = read, 0 = write.
REQ-011 In_RData  out  NCH*DW  per-channel registered read data.
REQ-012 In_Finish  out  NCH  per-channel one-cycle completion pulse.
REQ-013 In_Err  out  NCH  per-channel timeout flag, valid with In_Finish.
REQ-014 In_Busy  out  NCH  per-channel slot occupied: pending or in service.
REQ-015 O_Cmd  out  1  one-cycle downstream request strobe.
REQ-016 O_Addr / O_WData / O_RW  out  AW / DW / 1  downstream address, write data and direction of the granted channel.
REQ-017 O_RData  in  DW  downstream read data, sampled with O_Finish.
REQ-018 O_Finish  in  1  downstream completion strobe.

Function
REQ-019 Each channel SHALL have a one-deep slot capturing Addr, WData and RW when In_Cmd[i]=1 and the slot is free; In_Busy[i] SHALL rise the following cycle.
REQ-020 In_Cmd[i] while In_Busy[i]=1 SHALL be ignored, except in the DONE cycle of channel i, when it SHALL be captured.
REQ-021 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-022 IDLE: if any slot is pending, grant the first pending channel searching upward from last_grant+1 modulo NCH, then latch grant, set O_Cmd=1 for the next cycle and go to BUSY.
REQ-023 BUSY: O_Cmd SHALL be 0 after its first cycle; timeout counter increments each BUSY cycle.
REQ-024 BUSY with O_Finish=1 -> DONE: In_RData[g] <= O_RData, In_Err[g]=0.
REQ-025 BUSY with counter reaching TO_CYC and O_Finish=0 -> DONE: In_RData[g] <= all ones, In_Err[g]=1.
REQ-026 O_Finish and timeout on the same cycle SHALL count as normal completion.
REQ-027 DONE: In_Finish[g]=1 for exactly one cycle, slot g is freed, last_grant <= g, then -> IDLE; O_Finish in IDLE or DONE SHALL be ignored.
REQ-028 In_Err[g] and In_RData[g] SHALL hold until the next completion of channel g.
REQ-029 O_Addr, O_WData and O_RW SHALL come from slot g and stay stable from the O_Cmd cycle through DONE.
REQ-030 Latency: In_Cmd in cycle 0 with the FSM idle -> O_Cmd in cycle 2; O_Finish in cycle k -> In_Finish in cycle k+1; next O_Cmd no earlier than cycle k+3.
REQ-031 Write transactions SHALL still wait for O_Finish; In_RData[g] is updated with O_RData regardless of RW.

Reset
REQ-032 On rst=1, the following SHALL clear on the next edge: FSM <= IDLE; O_Cmd, In_Finish, In_Err, In_Busy and all slot valid bits <= 0; counter <= 0; last_grant <= NCH-1, so channel 0 wins first.
REQ-033 In_RData, O_Addr, O_WData and O_RW SHALL reset to 0.
REQ-034 A reset mid-transaction SHALL abort it silently: no In_Finish, downstream strobes dropped.

Verification
REQ-035 Single read: ch1 In_Cmd with Addr=16'h2002, RW=1; O_Finish 3 cycles after O_Cmd with O_RData=8'h5A -> In_RData[1]=8'h5A, In_Finish[1] one pulse, In_Err[1]=0.
REQ-036 All 4 channels strobe in the same cycle after reset -> grants in order 0,1,2,3; each channel gets exactly one O_Cmd.
REQ-037 Fairness: ch0 and ch2 each re-request in their DONE cycle for 8 rounds -> grants alternate 0,2,0,2 with no starvation.
REQ-038 Timeout with TO_CYC=4: O_Finish never asserted -> In_Finish[g] plus In_Err[g]=1 and In_RData[g]=8'hFF after 4 BUSY cycles.
REQ-039 Busy drop: second In_Cmd on ch3 while pending with a different address -> first address issued and only one transaction performed.
REQ-040 rst pulse during BUSY -> all outputs 0 the next cycle, no In_Finish, and a new request afterwards is served normally.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter sharing one downstream bus among NCH one-deep request slots
module bus_arbiter_rr #(
   parameter int NCH    = 4,
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int TO_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    In_Cmd,
   input  logic [NCH*AW-1:0] In_Addr,
   input  logic [NCH*DW-1:0] In_WData,
   input  logic [NCH-1:0]    In_RW,
   output logic [NCH*DW-1:0] In_RData,
   output logic [NCH-1:0]    In_Finish,
   output logic [NCH-1:0]    In_Err,
   output logic [NCH-1:0]    In_Busy,
   output logic              O_Cmd,
   output logic [AW-1:0]     O_Addr,
   output logic [DW-1:0]     O_WData,
   output logic              O_RW,
   input  logic [DW-1:0]     O_RData,
   input  logic              O_Finish
);
   localparam int GW = $clog2(NCH);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t            state_q, state_d;
   logic [NCH-1:0]    valid_q, valid_d, rw_q, rw_d, fin_q, fin_d, err_q, err_d;
   logic [NCH*AW-1:0] addr_q, addr_d;
   logic [NCH*DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [GW-1:0]     grant_q, grant_d, last_q, last_d, pick;
   logic [15:0]       cnt_q, cnt_d;
   logic              ocmd_q, ocmd_d, orw_q, orw_d, found;
   logic [AW-1:0]     oaddr_q, oaddr_d;
   logic [DW-1:0]     owdata_q, owdata_d;
   int                idx;
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      idx   = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(last_q) + k) % NCH;
         if (!found && valid_q[idx[GW-1:0]]) begin
            found = 1'b1;
            pick  = idx[GW-1:0];
         end
      end
   end
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rw_d     = rw_q;
      grant_d  = grant_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      fin_d    = '0;
      err_d    = err_q;
      ocmd_d   = 1'b0;
      oaddr_d  = oaddr_q;
      owdata_d = owdata_q;
      orw_d    = orw_q;
      if (state_q == DONE) begin
         valid_d[grant_q] = 1'b0;
         last_d           = grant_q;
         state_d          = IDLE;
      end
      // the finishing channel may refill its slot in its own DONE cycle
      for (int i = 0; i < NCH; i++) begin
         if (In_Cmd[i] && (!valid_q[i] || (state_q == DONE && grant_q == GW'(i)))) begin
            valid_d[i]           = 1'b1;
            addr_d[i*AW +: AW]   = In_Addr[i*AW +: AW];
            wdata_d[i*DW +: DW]  = In_WData[i*DW +: DW];
            rw_d[i]              = In_RW[i];
         end
      end
      if (state_q == IDLE && found) begin
         grant_d  = pick;
         ocmd_d   = 1'b1;
         oaddr_d  = addr_q[pick*AW +: AW];
         owdata_d = wdata_q[pick*DW +: DW];
         orw_d    = rw_q[pick];
         cnt_d    = '0;
         state_d  = BUSY;
      end
      if (state_q == BUSY) begin
         cnt_d = cnt_q + 16'd1;
         if (O_Finish || cnt_d == 16'(TO_CYC)) begin
            state_d                   = DONE;
            fin_d[grant_q]            = 1'b1;
            err_d[grant_q]            = !O_Finish;
            rdata_d[grant_q*DW +: DW] = O_Finish ? O_RData : {DW{1'b1}};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         valid_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rw_q     <= '0;
         grant_q  <= '0;
         last_q   <= GW'(NCH - 1);
         cnt_q    <= '0;
         rdata_q  <= '0;
         fin_q    <= '0;
         err_q    <= '0;
         ocmd_q   <= 1'b0;
         oaddr_q  <= '0;
         owdata_q <= '0;
         orw_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rw_q     <= rw_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         fin_q    <= fin_d;
         err_q    <= err_d;
         ocmd_q   <= ocmd_d;
         oaddr_q  <= oaddr_d;
         owdata_q <= owdata_d;
         orw_q    <= orw_d;
      end
   end
   assign In_RData  = rdata_q;
   assign In_Finish = fin_q;
   assign In_Err    = err_q;
   assign In_Busy   = valid_q;
   assign O_Cmd     = ocmd_q;
   assign O_Addr    = oaddr_q;
   assign O_WData   = owdata_q;
   assign O_RW      = orw_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scenarios plus randomized traffic against a timestamp-based reference model
module tb_bus_arbiter_rr;
   localparam int NCH = 4;
   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int TO  = 4;
   logic              clk, rst;
   logic [NCH-1:0]    in_cmd, in_rw, in_finish, in_err, in_busy;
   logic [NCH*AW-1:0] in_addr;
   logic [NCH*DW-1:0] in_wdata, in_rdata;
   logic              o_cmd, o_rw, o_finish;
   logic [AW-1:0]     o_addr;
   logic [DW-1:0]     o_wdata, o_rdata;
   int                checks = 0;
   int                failures = 0;

   bus_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .TO_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .In_Cmd(in_cmd), .In_Addr(in_addr), .In_WData(in_wdata), .In_RW(in_rw),
      .In_RData(in_rdata), .In_Finish(in_finish), .In_Err(in_err), .In_Busy(in_busy),
      .O_Cmd(o_cmd), .O_Addr(o_addr), .O_WData(o_wdata), .O_RW(o_rw),
      .O_RData(o_rdata), .O_Finish(o_finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      in_cmd = '0; in_rw = '0; in_addr = '0; in_wdata = '0; o_rdata = '0; o_finish = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({o_cmd, o_addr, o_wdata, o_rw, in_finish, in_err, in_busy, in_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got cmd=%b addr=%h wd=%h rw=%b fin=%b err=%b busy=%b rd=%h want all 0",
                  o_cmd, o_addr, o_wdata, o_rw, in_finish, in_err, in_busy, in_rdata);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      in_addr[1*AW +: AW] = 16'h2002; in_wdata[1*DW +: DW] = 8'h33; in_rw[1] = 1'b1; in_cmd = 4'b0010;
      @(negedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         in_cmd = '0;
         o_finish = (c == 5);
         o_rdata = (c == 5) ? 8'h5A : 8'h00;
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if ({in_busy, o_cmd} !== {4'b0010, 1'b0}) begin
               failures++; $display("FAIL rd_busy_c1 got busy=%b cmd=%b want busy=0010 cmd=0", in_busy, o_cmd);
            end
         end
         if (c == 2) begin
            checks++;
            if ({o_cmd, o_addr, o_wdata, o_rw} !== {1'b1, 16'h2002, 8'h33, 1'b1}) begin
               failures++; $display("FAIL rd_ocmd got cmd=%b addr=%h wd=%h rw=%b want 1 2002 33 1", o_cmd, o_addr, o_wdata, o_rw);
            end
         end
         if (c >= 3 && c <= 5) begin
            checks++;
            if ({o_cmd, in_finish} !== 5'b0) begin
               failures++; $display("FAIL rd_busy_phase c=%0d got cmd=%b fin=%b want 0 0000", c, o_cmd, in_finish);
            end
         end
         if (c == 6) begin
            checks++;
            if ({in_finish, in_err, in_rdata[1*DW +: DW], o_addr} !== {4'b0010, 4'b0000, 8'h5A, 16'h2002}) begin
               failures++; $display("FAIL rd_done got fin=%b err=%b rd=%h addr=%h want 0010 0000 5a 2002",
                                    in_finish, in_err, in_rdata[1*DW +: DW], o_addr);
            end
         end
         if (c == 7) begin
            checks++;
            if ({in_finish, in_busy, in_rdata[1*DW +: DW]} !== {4'b0, 4'b0, 8'h5A}) begin
               failures++; $display("FAIL rd_after got fin=%b busy=%b rd=%h want 0000 0000 5a", in_finish, in_busy, in_rdata[1*DW +: DW]);
            end
         end
      end
   endtask

   task automatic test_all_four();
      int q[$];
      int nfin[NCH];
      bit fn;
      do_reset();
      fn = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         in_addr[i*AW +: AW] = AW'(16'h1000 + i);
         nfin[i] = 0;
      end
      in_cmd = '1;
      @(negedge clk);
      for (int c = 1; c < 40; c++) begin
         @(posedge clk); #1;
         in_cmd = '0; o_finish = fn; fn = 1'b0; o_rdata = DW'(c);
         @(negedge clk);
         if (o_cmd) begin q.push_back(int'(o_addr) - 'h1000); fn = 1'b1; end
         for (int i = 0; i < NCH; i++) if (in_finish[i]) nfin[i]++;
      end
      o_finish = 1'b0;
      checks++;
      if (q.size() != NCH) begin failures++; $display("FAIL all4_count got=%0d want=%0d", q.size(), NCH); end
      for (int k = 0; k < NCH; k++) begin
         checks++;
         if (k >= q.size() || q[k] != k) begin
            failures++; $display("FAIL all4_order idx=%0d got=%0d want=%0d", k, (k < q.size()) ? q[k] : -1, k);
         end
         checks++;
         if (nfin[k] != 1) begin failures++; $display("FAIL all4_finish ch=%0d got=%0d want=1", k, nfin[k]); end
      end
   endtask

   task automatic test_fairness();
      int g[$];
      int req[NCH];
      bit fn;
      do_reset();
      fn = 1'b0;
      for (int i = 0; i < NCH; i++) req[i] = 1;
      in_addr[0*AW +: AW] = 16'h00A0; in_addr[2*AW +: AW] = 16'h00A2; in_cmd = 4'b0101;
      @(negedge clk);
      for (int c = 1; c < 200; c++) begin
         @(posedge clk); #1;
         in_cmd = '0; o_finish = fn; fn = 1'b0;
         @(negedge clk);
         if (o_cmd) begin
            g.push_back(o_addr == 16'h00A0 ? 0 : o_addr == 16'h00A2 ? 2 : 9);
            fn = 1'b1;
         end
         // re-request inside the DONE cycle, sampled at the edge that ends it
         for (int ch = 0; ch < NCH; ch += 2) begin
            if (in_finish[ch] && req[ch] < 8) begin in_cmd[ch] = 1'b1; req[ch]++; end
         end
      end
      o_finish = 1'b0;
      checks++;
      if (g.size() != 16) begin failures++; $display("FAIL fair_count got=%0d want=16", g.size()); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (k >= g.size() || g[k] != (k % 2) * 2) begin
            failures++; $display("FAIL fair_order idx=%0d got=%0d want=%0d", k, (k < g.size()) ? g[k] : -1, (k % 2) * 2);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      in_addr[2*AW +: AW] = 16'h0C0C; in_cmd = 4'b0100;
      @(negedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         in_cmd = '0; o_finish = 1'b0;
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if ({o_cmd, o_addr} !== {1'b1, 16'h0C0C}) begin
               failures++; $display("FAIL to_ocmd got cmd=%b addr=%h want 1 0c0c", o_cmd, o_addr);
            end
         end
         if (c == 5) begin
            checks++;
            if (in_finish !== 4'b0) begin failures++; $display("FAIL to_early got fin=%b want 0000", in_finish); end
         end
         if (c == 6) begin
            checks++;
            if ({in_finish, in_err, in_rdata[2*DW +: DW]} !== {4'b0100, 4'b0100, 8'hFF}) begin
               failures++; $display("FAIL to_done got fin=%b err=%b rd=%h want 0100 0100 ff",
                                    in_finish, in_err, in_rdata[2*DW +: DW]);
            end
         end
         if (c == 7) begin
            checks++;
            if ({in_finish, in_err, in_rdata[2*DW +: DW], in_busy} !== {4'b0, 4'b0100, 8'hFF, 4'b0}) begin
               failures++; $display("FAIL to_hold got fin=%b err=%b rd=%h busy=%b want 0000 0100 ff 0000",
                                    in_finish, in_err, in_rdata[2*DW +: DW], in_busy);
            end
         end
      end
   endtask

   task automatic test_busy_drop();
      int n;
      logic [AW-1:0] first;
      bit fn;
      do_reset();
      n = 0; first = '0; fn = 1'b0;
      in_addr[3*AW +: AW] = 16'h3333; in_cmd = 4'b1000;
      @(negedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         in_cmd = (c <= 2) ? 4'b1000 : 4'b0000;
         in_addr[3*AW +: AW] = 16'h4444;
         o_finish = fn; fn = 1'b0; o_rdata = 8'h66;
         @(negedge clk);
         if (o_cmd) begin n++; if (n == 1) first = o_addr; fn = 1'b1; end
      end
      o_finish = 1'b0;
      checks++;
      if (n != 1) begin failures++; $display("FAIL drop_count got=%0d want=1", n); end
      checks++;
      if (first !== 16'h3333) begin failures++; $display("FAIL drop_addr got=%h want=3333", first); end
      checks++;
      if ({in_busy, in_rdata[3*DW +: DW]} !== {4'b0, 8'h66}) begin
         failures++; $display("FAIL drop_end got busy=%b rd=%h want 0000 66", in_busy, in_rdata[3*DW +: DW]);
      end
   endtask

   task automatic test_reset_mid();
      bit saw;
      int n;
      bit fn;
      do_reset();
      in_addr[0*AW +: AW] = 16'hBEEF; in_wdata[0*DW +: DW] = 8'h77; in_cmd = 4'b0001;
      @(negedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         in_cmd = '0; o_finish = (c == 3); o_rdata = 8'hC3;
         @(negedge clk);
      end
      checks++;
      if (in_rdata[0*DW +: DW] !== 8'hC3) begin failures++; $display("FAIL mid_pre got=%h want=c3", in_rdata[0*DW +: DW]); end
      @(posedge clk); #1;
      o_finish = 1'b0; in_addr[1*AW +: AW] = 16'h1234; in_wdata[1*DW +: DW] = 8'h99; in_rw[1] = 1'b1; in_cmd = 4'b0010;
      @(negedge clk);
      @(posedge clk); #1; in_cmd = '0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({o_cmd, o_addr} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL mid_ocmd got cmd=%b addr=%h want 1 1234", o_cmd, o_addr); end
      @(posedge clk); #1; rst = 1'b1; o_finish = 1'b1; o_rdata = 8'hEE;
      @(negedge clk);
      @(posedge clk); #1; rst = 1'b0; o_finish = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_cmd, o_addr, o_wdata, o_rw, in_finish, in_err, in_busy, in_rdata} !== '0) begin
         failures++;
         $display("FAIL mid_zero got cmd=%b addr=%h wd=%h rw=%b fin=%b err=%b busy=%b rd=%h want all 0",
                  o_cmd, o_addr, o_wdata, o_rw, in_finish, in_err, in_busy, in_rdata);
      end
      saw = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (o_cmd || in_finish != 0) saw = 1'b1;
      end
      checks++;
      if (saw) begin failures++; $display("FAIL mid_silent got activity=1 want=0"); end
      @(posedge clk); #1;
      in_addr[2*AW +: AW] = 16'h2222; in_cmd = 4'b0100;
      @(negedge clk);
      n = 0; saw = 1'b0; fn = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         in_cmd = '0; o_finish = fn; fn = 1'b0; o_rdata = 8'h42;
         @(negedge clk);
         if (o_cmd) begin n++; fn = 1'b1; end
         if (in_finish == 4'b0100 && in_rdata[2*DW +: DW] == 8'h42 && in_err == 4'b0) saw = 1'b1;
      end
      o_finish = 1'b0;
      checks++;
      if (n != 1 || !saw) begin failures++; $display("FAIL mid_recover got ocmds=%0d finished=%0d want 1 1", n, saw); end
   endtask

   task automatic test_random();
      logic [NCH-1:0]    mb, nb, merr, cmd;
      logic [NCH*DW-1:0] mrd;
      logic [AW-1:0]     ra[NCH];
      logic [DW-1:0]     rwd[NCH];
      logic              rrw[NCH];
      logic [AW-1:0]     ea;
      logic [DW-1:0]     ew, ord;
      logic              er, ofin;
      int                active, t_cmd, t_done, dly, last, idx;
      bit                is_done;
      do_reset();
      mb = '0; merr = '0; mrd = '0; active = -1; t_cmd = -1; t_done = -1; dly = 0; last = NCH - 1;
      ea = '0; ew = '0; er = 1'b0;
      for (int i = 0; i < NCH; i++) begin ra[i] = '0; rwd[i] = '0; rrw[i] = 1'b0; end
      for (int t = 0; t < 3000; t++) begin
         is_done = (active >= 0 && t == t_done);
         for (int i = 0; i < NCH; i++) begin
            cmd[i] = ($urandom_range(3) == 0);
            in_addr[i*AW +: AW] = AW'($urandom);
            in_wdata[i*DW +: DW] = DW'($urandom);
            in_rw[i] = 1'($urandom_range(1));
         end
         in_cmd = cmd;
         ord = DW'($urandom);
         if (active >= 0 && t >= t_cmd && t_done < 0) ofin = (t == t_cmd + dly);
         else ofin = ($urandom_range(7) == 0);
         o_finish = ofin; o_rdata = ord;
         @(negedge clk);
         checks++;
         if (o_cmd !== (active >= 0 && t == t_cmd)) begin
            failures++; $display("FAIL rnd_ocmd t=%0d got=%b want=%b", t, o_cmd, (active >= 0 && t == t_cmd));
         end
         checks++;
         if (in_finish !== (is_done ? NCH'(1) << active : NCH'(0))) begin
            failures++; $display("FAIL rnd_finish t=%0d got=%b want=%b", t, in_finish, is_done ? NCH'(1) << active : NCH'(0));
         end
         checks++;
         if (in_busy !== mb) begin failures++; $display("FAIL rnd_busy t=%0d got=%b want=%b", t, in_busy, mb); end
         checks++;
         if ({in_err, in_rdata} !== {merr, mrd}) begin
            failures++; $display("FAIL rnd_result t=%0d got err=%b rd=%h want err=%b rd=%h", t, in_err, in_rdata, merr, mrd);
         end
         if (active >= 0 && t >= t_cmd) begin
            checks++;
            if ({o_addr, o_wdata, o_rw} !== {ea, ew, er}) begin
               failures++; $display("FAIL rnd_bus t=%0d got %h/%h/%b want %h/%h/%b", t, o_addr, o_wdata, o_rw, ea, ew, er);
            end
         end
         if (active >= 0 && !is_done && t >= t_cmd) begin
            if (ofin) begin
               t_done = t + 1; merr[active] = 1'b0; mrd[active*DW +: DW] = ord;
            end else if (t - t_cmd + 1 == TO) begin
               t_done = t + 1; merr[active] = 1'b1; mrd[active*DW +: DW] = '1;
            end
         end
         nb = mb;
         for (int i = 0; i < NCH; i++) begin
            if (cmd[i] && (!mb[i] || (is_done && i == active))) begin
               nb[i] = 1'b1; ra[i] = in_addr[i*AW +: AW]; rwd[i] = in_wdata[i*DW +: DW]; rrw[i] = in_rw[i];
            end else if (is_done && i == active) nb[i] = 1'b0;
         end
         if (is_done) begin
            last = active; active = -1; t_done = -1;
         end else if (active < 0) begin
            for (int k = 1; k <= NCH; k++) begin
               idx = (last + k) % NCH;
               if (active < 0 && mb[idx]) active = idx;
            end
            if (active >= 0) begin
               t_cmd = t + 1; ea = ra[active]; ew = rwd[active]; er = rrw[active]; dly = $urandom_range(0, 5);
            end
         end
         mb = nb;
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_all_four();
      test_fairness();
      test_timeout();
      test_busy_drop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
